// File: rtl/exu_chn_dispatch_if.sv
// Handshake bundle between issue, the execute dispatcher and its channel handlers.
// slave = dispatcher side, master = issue logic plus handlers.
interface exu_chn_dispatch_if #(
    parameter int CHN_NUM = 5,
    parameter int PKT_W   = 96
);
    logic               req_vld;
    logic               req_rdy;
    logic [PKT_W-1:0]   req_pkt;
    logic [CHN_NUM-1:0] req_chn;
    logic               fl_vld;
    logic [CHN_NUM-1:0] chn_sel;
    logic [PKT_W-1:0]   chn_pkt;
    logic [CHN_NUM-1:0] chn_done;
    logic               busy;
    logic               err_vld;
    logic [1:0]         err_code;

    modport slave (
        input  req_vld, req_pkt, req_chn, fl_vld, chn_done,
        output req_rdy, chn_sel, chn_pkt, busy, err_vld, err_code
    );

    modport master (
        output req_vld, req_pkt, req_chn, fl_vld, chn_done,
        input  req_rdy, chn_sel, chn_pkt, busy, err_vld, err_code
    );
endinterface

// File: rtl/exu_chn_dispatch.sv
// Execute-stage dispatcher: holds one instruction, drives a one-hot handler select.
// Define EXU_DISP_WDOG_EN to enable the multi-cycle handler watchdog.
module exu_chn_dispatch #(
    parameter int                 CHN_NUM    = 5,
    parameter int                 PKT_W      = 96,
    parameter logic [CHN_NUM-1:0] MULTI_MASK = CHN_NUM'(5'b00110),
    parameter int                 TO_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    exu_chn_dispatch_if.slave  bus
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state, state_nxt;
    logic [CHN_NUM-1:0] held_chn_p1;
    logic [PKT_W-1:0]   chn_pkt_p1;
    logic               drop, drop_nxt;
    logic               err_vld_p1;
    logic [1:0]         err_code_p1;
    logic [TO_W-1:0]    wd_cnt;

    logic held_multi, done_hit, wd_expire, complete;
    logic rdy, fire, legal, load, illegal;

`ifdef EXU_DISP_WDOG_EN
    localparam bit WDOG_ON = 1'b1;

    // Counter saturates; expiry is only acted on while the held channel is multi-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (load) begin
            wd_cnt <= '0;
        end else if ((state == S_BUSY) && held_multi && !(&wd_cnt)) begin
            wd_cnt <= wd_cnt + TO_W'(1);
        end
    end
`else
    localparam bit WDOG_ON = 1'b0;

    assign wd_cnt = '0;
`endif

    always_comb begin
        held_multi = |(held_chn_p1 & MULTI_MASK);
        done_hit   = |(held_chn_p1 & MULTI_MASK & bus.chn_done);
        wd_expire  = WDOG_ON && (state == S_BUSY) && held_multi && (&wd_cnt) && !done_hit;
        complete   = (state == S_BUSY) && (!held_multi || done_hit || wd_expire);

        // A pending drop keeps the port open so the victim request can be swallowed.
        rdy     = drop || (state == S_IDLE) || complete;
        fire    = bus.req_vld && rdy;
        legal   = $onehot(bus.req_chn);
        load    = fire && !drop && legal;
        illegal = fire && !drop && !legal;

        drop_nxt = drop;
        if (bus.fl_vld) begin
            drop_nxt = 1'b1;
        end else if (fire && drop) begin
            drop_nxt = 1'b0;
        end

        state_nxt = state;
        if (load) begin
            state_nxt = S_BUSY;
        end else if (complete) begin
            state_nxt = S_IDLE;
        end
    end

    // ---- stage p1: held instruction and error pulse ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            drop        <= 1'b0;
            held_chn_p1 <= '0;
            chn_pkt_p1  <= '0;
            err_vld_p1  <= 1'b0;
            err_code_p1 <= 2'd0;
        end else begin
            state      <= state_nxt;
            drop       <= drop_nxt;
            err_vld_p1 <= illegal || wd_expire;
            if (illegal) begin
                err_code_p1 <= 2'd1;
            end else if (wd_expire) begin
                err_code_p1 <= 2'd2;
            end else begin
                err_code_p1 <= 2'd0;
            end
            if (load) begin
                held_chn_p1 <= bus.req_chn;
                chn_pkt_p1  <= bus.req_pkt;
            end
        end
    end

    assign bus.req_rdy  = rdy;
    assign bus.chn_sel  = (state == S_BUSY) ? held_chn_p1 : '0;
    assign bus.chn_pkt  = chn_pkt_p1;
    assign bus.busy     = (state == S_BUSY);
    assign bus.err_vld  = err_vld_p1;
    assign bus.err_code = err_code_p1;

endmodule

// File: tb/tb_exu_chn_dispatch.sv
// Scoreboard bench for exu_chn_dispatch: stimulus pushes expected dispatches/errors,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_exu_chn_dispatch;

    typedef struct {
        logic [4:0]  sel;
        logic [95:0] pkt;
        int          dur;
    } disp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    disp_t disp_q[$];
    int    err_q[$];

    exu_chn_dispatch_if #(.CHN_NUM(5), .PKT_W(96)) bus ();

    exu_chn_dispatch #(
        .CHN_NUM   (5),
        .PKT_W     (96),
        .MULTI_MASK(5'b00110),
        .TO_W      (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [95:0] mk(input int n);
        return {32'(n), 32'hC0DE_0000 + 32'(n), 32'(n * 13)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] chn, input logic [95:0] pkt,
                         input logic fl, input logic [4:0] done);
        bus.req_vld  = v;
        bus.req_chn  = chn;
        bus.req_pkt  = pkt;
        bus.fl_vld   = fl;
        bus.chn_done = done;
    endtask

    task automatic idle();
        drive(1'b0, 5'b0, 96'b0, 1'b0, 5'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_disp(input logic [4:0] sel, input logic [95:0] pkt, input int dur);
        disp_t d;
        d.sel = sel;
        d.pkt = pkt;
        d.dur = dur;
        disp_q.push_back(d);
    endtask

    // Monitor state, owned by the monitor process only
    logic [4:0]  mon_prev_sel;
    logic [95:0] mon_prev_pkt;
    bit          mon_run;
    int          mon_len;
    int          mon_dur;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_run      = 1'b0;
            mon_prev_sel = '0;
            mon_prev_pkt = '0;
        end else begin
            if (bus.err_vld) begin
                if (err_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_err actual=code %0d required=no error", bus.err_code);
                end else begin
                    chk("err_code", 128'(bus.err_code), 128'(err_q.pop_front()));
                end
            end
            begin
                bit    is_new;
                disp_t d;
                is_new = (bus.chn_sel != 5'b0) &&
                         ((mon_prev_sel == 5'b0) || (bus.chn_sel != mon_prev_sel) ||
                          (bus.chn_pkt != mon_prev_pkt));
                if (mon_run && ((bus.chn_sel == 5'b0) || is_new)) begin
                    if (mon_dur != 0) chk("sel_duration", 128'(mon_len), 128'(mon_dur));
                    mon_run = 1'b0;
                end
                if (is_new) begin
                    if (disp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_dispatch actual=sel %b pkt %0h required=none",
                                 bus.chn_sel, bus.chn_pkt);
                    end else begin
                        d = disp_q.pop_front();
                        chk("disp_sel", 128'(bus.chn_sel), 128'(d.sel));
                        chk("disp_pkt", 128'(bus.chn_pkt), 128'(d.pkt));
                        mon_run = 1'b1;
                        mon_len = 1;
                        mon_dur = d.dur;
                    end
                end else if (mon_run && (bus.chn_sel != 5'b0)) begin
                    mon_len++;
                end
            end
            mon_prev_sel = bus.chn_sel;
            mon_prev_pkt = bus.chn_pkt;
        end
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle();
        #2;
        chk("rst_chn_sel", 128'(bus.chn_sel), 128'(0));
        chk("rst_chn_pkt", 128'(bus.chn_pkt), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_err_vld", 128'(bus.err_vld), 128'(0));
        chk("rst_err_code", 128'(bus.err_code), 128'(0));
        chk("rst_req_rdy", 128'(bus.req_rdy), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Back-to-back single-cycle dispatches
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'b00001, mk(i), 1'b0, 5'b0);
            #1;
            chk("b2b_rdy", 128'(bus.req_rdy), 128'(1));
            push_disp(5'b00001, mk(i), 1);
            tick();
        end
        idle();
        tick();
        tick();

        // Multi-cycle channel 2, done three cycles after select
        drive(1'b1, 5'b00100, mk(10), 1'b0, 5'b0);
        push_disp(5'b00100, mk(10), 4);
        tick();
        idle();
        #1;
        chk("multi_rdy_c1", 128'(bus.req_rdy), 128'(0));
        tick();
        bus.chn_done = 5'b00010;
        #1;
        chk("multi_rdy_c2_otherdone", 128'(bus.req_rdy), 128'(0));
        tick();
        bus.chn_done = 5'b0;
        #1;
        chk("multi_rdy_c3", 128'(bus.req_rdy), 128'(0));
        tick();
        drive(1'b1, 5'b00001, mk(11), 1'b0, 5'b00100);
        #1;
        chk("multi_rdy_done", 128'(bus.req_rdy), 128'(1));
        push_disp(5'b00001, mk(11), 1);
        tick();
        idle();
        tick();
        tick();

        // Flush in IDLE: first request swallowed, second dispatched
        drive(1'b0, 5'b0, 96'b0, 1'b1, 5'b0);
        tick();
        drive(1'b1, 5'b00001, mk(20), 1'b0, 5'b0);
        #1;
        chk("flush_drop_rdy", 128'(bus.req_rdy), 128'(1));
        tick();
        chk("flush_drop_sel", 128'(bus.chn_sel), 128'(0));
        drive(1'b1, 5'b00001, mk(21), 1'b0, 5'b0);
        push_disp(5'b00001, mk(21), 1);
        tick();
        idle();
        tick();

        // Flush during a BUSY multi-cycle op on channel 1
        drive(1'b1, 5'b00010, mk(30), 1'b0, 5'b0);
        push_disp(5'b00010, mk(30), 4);
        tick();
        drive(1'b0, 5'b0, 96'b0, 1'b1, 5'b0);
        #1;
        chk("busyfl_rdy_c1", 128'(bus.req_rdy), 128'(0));
        tick();
        drive(1'b1, 5'b00001, mk(31), 1'b0, 5'b0);
        #1;
        chk("busyfl_rdy_drop", 128'(bus.req_rdy), 128'(1));
        tick();
        idle();
        #1;
        chk("busyfl_still_busy", 128'(bus.busy), 128'(1));
        chk("busyfl_rdy_c3", 128'(bus.req_rdy), 128'(0));
        tick();
        bus.chn_done = 5'b00010;
        tick();
        idle();
        chk("busyfl_done_idle", 128'(bus.busy), 128'(0));
        tick();

        // Flush and request together while drop is set: flush wins
        drive(1'b0, 5'b0, 96'b0, 1'b1, 5'b0);
        tick();
        drive(1'b1, 5'b00001, mk(40), 1'b1, 5'b0);
        tick();
        drive(1'b1, 5'b00001, mk(41), 1'b0, 5'b0);
        tick();
        drive(1'b1, 5'b00001, mk(42), 1'b0, 5'b0);
        push_disp(5'b00001, mk(42), 1);
        tick();
        idle();
        tick();

        // Flush with drop clear: same-cycle request dispatches, next one is dropped
        drive(1'b1, 5'b00001, mk(43), 1'b1, 5'b0);
        push_disp(5'b00001, mk(43), 1);
        tick();
        drive(1'b1, 5'b00001, mk(44), 1'b0, 5'b0);
        tick();
        drive(1'b1, 5'b00001, mk(45), 1'b0, 5'b0);
        push_disp(5'b00001, mk(45), 1);
        tick();
        idle();
        tick();

        // Illegal channel codes
        drive(1'b1, 5'b00011, mk(50), 1'b0, 5'b0);
        #1;
        chk("illegal_rdy", 128'(bus.req_rdy), 128'(1));
        push_err(1);
        tick();
        idle();
        chk("illegal_sel", 128'(bus.chn_sel), 128'(0));
        chk("illegal_busy", 128'(bus.busy), 128'(0));
        drive(1'b1, 5'b00000, mk(51), 1'b0, 5'b0);
        push_err(1);
        tick();
        drive(1'b1, 5'b01000, mk(52), 1'b0, 5'b0);
        push_disp(5'b01000, mk(52), 1);
        tick();
        drive(1'b1, 5'b10100, mk(53), 1'b0, 5'b0);
        push_err(1);
        tick();
        idle();
        chk("illegal_after_single_idle", 128'(bus.busy), 128'(0));
        tick();
        tick();

`ifdef EXU_DISP_WDOG_EN
        // Watchdog force-completion after 15 full BUSY cycles
        drive(1'b1, 5'b00100, mk(60), 1'b0, 5'b0);
        push_disp(5'b00100, mk(60), 16);
        push_err(2);
        tick();
        idle();
        for (int c = 1; c <= 15; c++) begin
            #1;
            chk("wdog_wait_rdy", 128'(bus.req_rdy), 128'(0));
            tick();
        end
        #1;
        chk("wdog_expire_rdy", 128'(bus.req_rdy), 128'(1));
        tick();
        chk("wdog_after_busy", 128'(bus.busy), 128'(0));
        tick();
        tick();
        drive(1'b1, 5'b00010, mk(61), 1'b0, 5'b0);
        push_disp(5'b00010, mk(61), 0);
        tick();
        idle();
        tick();
        tick();
`else
        // No watchdog: a multi-cycle op without done stays held
        drive(1'b1, 5'b00100, mk(60), 1'b0, 5'b0);
        push_disp(5'b00100, mk(60), 0);
        tick();
        idle();
        repeat (100) tick();
        chk("nowdog_busy", 128'(bus.busy), 128'(1));
        chk("nowdog_sel", 128'(bus.chn_sel), 128'(5'b00100));
`endif

        // Asynchronous reset while a multi-cycle op is held
        chk("prerst_busy", 128'(bus.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 128'(bus.chn_sel), 128'(0));
        chk("async_rst_busy", 128'(bus.busy), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 128'(bus.req_rdy), 128'(1));
        tick();
        tick();

        chk("disp_q_empty", 128'(disp_q.size()), 128'(0));
        chk("err_q_empty", 128'(err_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic push_err(input int code);
        err_q.push_back(code);
    endtask

endmodule

// File: doc/exu_chn_dispatch.md
# exu_chn_dispatch

Parametrised execute-stage dispatcher that sits between the decode/issue handshake and a set of `CHN_NUM` instruction handlers (ALU, branch, load/store, misc, system, …). It registers each accepted instruction and drives a one-hot channel select. It completes single-cycle channels implicitly and waits on `chn_done` for multi-cycle channels. It applies flush-drop semantics and reports illegal channel codes instead of stalling. An optional watchdog force-completes hung multi-cycle handlers.

## Interface
- `CHN_NUM`, 5, number of handler channels (2..16).
- `PKT_W`, 96, width of the opaque instruction packet (pc, ir, prediction fields).
- `MULTI_MASK`, `5'b00110`, bit i set means channel i is multi-cycle and completes on `chn_done[i]`.
- `TO_W`, 8, watchdog counter width.

Ports (reset is asynchronous, active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_vld` in 1: instruction valid.
- `req_rdy` out 1: instruction accepted when `req_vld & req_rdy`.
- `req_pkt` in `PKT_W`: instruction packet.
- `req_chn` in `CHN_NUM`: one-hot target channel from the decoder.
- `fl_vld` in 1: pipeline flush pulse.
- `chn_sel` out `CHN_NUM`: one-hot handler select.
- `chn_pkt` out `PKT_W`: registered packet for the selected handler.
- `chn_done` in `CHN_NUM`: per-channel completion. Only sampled for multi-cycle channels while selected.
- `busy` out 1: an instruction is held in the dispatcher.
- `err_vld` out 1: one-cycle error pulse.
- `err_code` out 2: 1 = illegal channel, 2 = watchdog timeout. Valid with `err_vld`.

## Operation
- State machine:
  - IDLE: nothing held.
  - BUSY: holding register valid; `chn_sel` = held one-hot; `busy` = 1.
- Accept in IDLE:
  - `req_rdy` = 1.
  - A legal request loads `chn_pkt` and the held channel, then goes to BUSY.
- Completion in BUSY:
  - A single-cycle channel completes in its first BUSY cycle.
  - A multi-cycle channel completes in the cycle `chn_done[held]` = 1.
  - `req_rdy` = completion. If a new legal request is accepted in the completion cycle, stay in BUSY with the new packet. Otherwise go to IDLE.
- Illegal request (`req_chn` zero or multi-hot):
  - Accepted whenever `req_rdy` = 1 and dropped.
  - `err_vld` = 1, `err_code` = 1 the next cycle.
  - State follows the completion rule as if no request arrived.
- Flush:
  - `fl_vld` sets a sticky `drop` flag.
  - While `drop` = 1, `req_rdy` = 1 regardless of state. An arriving `req_vld` is consumed and discarded, clearing `drop`. Exactly one request is dropped per flush.
  - `fl_vld` and `req_vld` in the same cycle with `drop` = 1: the request is dropped and `drop` stays set (flush wins).
  - `fl_vld` with `drop` = 0: the request that cycle is dispatched normally; the effect starts next cycle.
  - An in-flight BUSY instruction is never aborted by flush; it runs to completion.
  - A request consumed by drop while BUSY does not complete the held instruction.
- `chn_done` for a non-selected channel, or for a single-cycle channel, is ignored.

## Timing
- Reset values: state IDLE, `drop` = 0, `chn_sel` = 0, `chn_pkt` = 0, `busy` = 0, `err_vld` = 0, `err_code` = 0, watchdog counter = 0. `req_rdy` = 1 after reset.
- Dispatch latency: `chn_sel` rises the cycle after acceptance.
- A single-cycle channel sees `chn_sel` for exactly one cycle per instruction. Throughput is 1 instruction/cycle.
- A multi-cycle channel sees `chn_sel` from acceptance+1 through the `chn_done` cycle inclusive. Minimum occupancy is 1 cycle (`chn_done` in the first BUSY cycle).
- `req_rdy` is combinational from state, `drop`, `chn_done` and the watchdog; it has no path from `req_vld`.
- `err_vld` is registered, high for one cycle.
- Reset mid-operation clears all state asynchronously; the held instruction is lost.

## Configuration
- `EXU_DISP_WDOG_EN` defined: a `TO_W`-bit counter clears on entering BUSY and increments each BUSY cycle of a multi-cycle channel.
  - When it reaches all-ones without `chn_done`, the instruction force-completes that cycle (`req_rdy` = 1, same rules as a normal completion).
  - The next cycle: `err_vld` = 1, `err_code` = 2.
  - `chn_done` in the saturating cycle counts as a normal completion with no error.
- Undefined: no counter; multi-cycle channels wait indefinitely; `err_code` 2 is never produced.

## Test plan
- Back-to-back single-cycle: `req_chn` = `00001` for 4 consecutive cycles, `req_vld` = 1 -> `req_rdy` held at 1, `chn_sel` = `00001` for 4 cycles starting 1 cycle later, `chn_pkt` tracks each packet.
- Multi-cycle: `req_chn` = `00100`, `chn_done[2]` asserted 3 cycles after `chn_sel` rises -> `chn_sel` high for 4 cycles, `req_rdy` = 0 for the first 3 BUSY cycles, then a next request accepted in the done cycle.
- Flush: `fl_vld` pulse, then 2 requests on `00001` -> first consumed with `chn_sel` staying 0, second dispatched. Flush during a BUSY `00010` op -> that op still waits for `chn_done[1]`.
- Illegal: `req_chn` = `00011` -> accepted, `chn_sel` stays 0, `err_vld` = 1 with `err_code` = 1 one cycle later. `req_chn` = `00000` gives the same response.
- Watchdog (`EXU_DISP_WDOG_EN`, `TO_W` = 4): `req_chn` = `00100`, no `chn_done` -> force-complete after 15 BUSY cycles, then `err_code` = 2 pulse. Without the macro -> `busy` stays 1 after 100 cycles.
- Async reset asserted while BUSY on a multi-cycle channel -> `chn_sel` = 0 and `busy` = 0 immediately, `req_rdy` = 1 after release.
